// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - float operand classes, exception flag bundle and encoding helpers
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  // Encodings are built 64 bits wide; callers keep the low EXP_W+MAN_W+1 bits.
  localparam int FP_ENC_W = 64;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_ENC_W-1:0] fp_inf(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  function automatic logic [FP_ENC_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - combinational normalise, round-to-nearest-even and pack stage
// Optional FP_MUL_FLAGS_EN adds the flags output.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                    sign,
  input  fp_class_e               cls,
  input  logic signed [EXP_W+1:0] exp_sum,
  input  logic [2*MAN_W+1:0]      prod,
  output logic [EXP_W+MAN_W:0]    z
`ifdef FP_MUL_FLAGS_EN
  ,
  output fp_flags_t               flags
`endif
);

  localparam int W = EXP_W + MAN_W + 1;
  localparam logic [FP_ENC_W-1:0] INF64  = fp_inf(EXP_W, MAN_W);
  localparam logic [FP_ENC_W-1:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-2:0] INF_MAG = INF64[W-2:0];
  localparam logic [W-1:0] QNAN    = QNAN64[W-1:0];
  localparam logic signed [EXP_W+1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  logic [2*MAN_W+1:0]      norm;
  logic [MAN_W:0]          mant;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [MAN_W+1:0]        rounded;
  logic signed [EXP_W+1:0] exp_fin;
  logic [MAN_W-1:0]        frac;
  logic                    ovf;
  logic                    unf;

  always_comb begin
    // Left-align so the leading one always sits at the top bit.
    norm     = prod[2*MAN_W+1] ? prod : (prod << 1);
    mant     = norm[2*MAN_W+1:MAN_W+1];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | mant[0]);
    rounded  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, round_up};
    exp_fin  = exp_sum + {{(EXP_W+1){1'b0}}, prod[2*MAN_W+1]}
                       + {{(EXP_W+1){1'b0}}, rounded[MAN_W+1]};
    frac     = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    ovf      = exp_fin >= EXP_MAX;
    unf      = exp_fin <= EXP_ZERO;

    z = '0;
    case (cls)
      FP_NAN:  z = QNAN;
      FP_INF:  z = {sign, INF_MAG};
      FP_ZERO: z = {sign, {(W-1){1'b0}}};
      default: begin
        if (ovf)      z = {sign, INF_MAG};
        else if (unf) z = {sign, {(W-1){1'b0}}};
        else          z = {sign, exp_fin[EXP_W-1:0], frac};
      end
    endcase
  end

`ifdef FP_MUL_FLAGS_EN
  always_comb begin
    flags           = '0;
    flags.invalid   = (cls == FP_NAN);
    flags.overflow  = (cls == FP_NORM) & ovf;
    flags.underflow = (cls == FP_NORM) & ~ovf & unf;
    flags.inexact   = (cls == FP_NORM) & (guard | sticky | ovf | unf);
  end
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined IEEE-754 multiplier, RNE, subnormals flushed
// Optional FP_MUL_FLAGS_EN adds out_flags = {invalid, overflow, underflow, inexact}.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_z,
  output logic [TAG_W-1:0]     out_tag
`ifdef FP_MUL_FLAGS_EN
  ,
  output logic [3:0]           out_flags
`endif
);

  localparam int W = EXP_W + MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(fp_bias(EXP_W));

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  function automatic fp_class_e classify(input logic [W-1:0] x);
    if (x[W-2:MAN_W] == '0)      return FP_ZERO;
    if (x[W-2:MAN_W] == EXP_ONES) return (x[MAN_W-1:0] == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

  fp_class_e ca, cb, cls_in;

  always_comb begin
    ca = classify(in_a);
    cb = classify(in_b);
    if (ca == FP_NAN || cb == FP_NAN ||
        (ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF))
      cls_in = FP_NAN;
    else if (ca == FP_INF || cb == FP_INF)
      cls_in = FP_INF;
    else if (ca == FP_ZERO || cb == FP_ZERO)
      cls_in = FP_ZERO;
    else
      cls_in = FP_NORM;
  end

  logic                    s1_valid, s1_sign;
  fp_class_e               s1_cls;
  logic [EXP_W-1:0]        s1_exp_a, s1_exp_b;
  logic [MAN_W:0]          s1_sig_a, s1_sig_b;
  logic [TAG_W-1:0]        s1_tag;

  logic                    s2_valid, s2_sign;
  fp_class_e               s2_cls;
  logic signed [EXP_W+1:0] s2_exp;
  logic [2*MAN_W+1:0]      s2_prod;
  logic [TAG_W-1:0]        s2_tag;

  logic [W-1:0]            rp_z;
`ifdef FP_MUL_FLAGS_EN
  fp_flags_t               rp_flags;
`endif

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign    (s2_sign),
    .cls     (s2_cls),
    .exp_sum (s2_exp),
    .prod    (s2_prod),
    .z       (rp_z)
`ifdef FP_MUL_FLAGS_EN
    ,
    .flags   (rp_flags)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_cls    <= FP_ZERO;
      s1_exp_a  <= '0;
      s1_exp_b  <= '0;
      s1_sig_a  <= '0;
      s1_sig_b  <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_cls    <= FP_ZERO;
      s2_exp    <= '0;
      s2_prod   <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
`ifdef FP_MUL_FLAGS_EN
      out_flags <= '0;
`endif
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_a[W-1] ^ in_b[W-1];
      s1_cls    <= cls_in;
      s1_exp_a  <= in_a[W-2:MAN_W];
      s1_exp_b  <= in_b[W-2:MAN_W];
      s1_sig_a  <= {1'b1, in_a[MAN_W-1:0]};
      s1_sig_b  <= {1'b1, in_b[MAN_W-1:0]};
      s1_tag    <= in_tag;

      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_cls    <= s1_cls;
      s2_exp    <= $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - BIAS;
      s2_prod   <= {{(MAN_W+1){1'b0}}, s1_sig_a} * {{(MAN_W+1){1'b0}}, s1_sig_b};
      s2_tag    <= s1_tag;

      out_valid <= s2_valid;
      out_z     <= rp_z;
      out_tag   <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
      out_flags <= rp_flags;
`endif
    end
  end

endmodule
